mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the processor's data-memory bus, beside `dmem`. Consumes the core's store stream (`memwrite`, `Data_add`, `write_data`) and decodes stores to its own address window. Bytes queue in a small FIFO and are serialised as 8N1 frames on `tx`. A combinational status word is returned for loads, and the top level muxes it with `dmem` read data.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, ≥2.
- `FIFO_DEPTH`, 4: byte entries; power of two, ≥2.
- `BASE_ADDR`, 32'h0000_0100: word-aligned base of the 8-byte register window.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `memwrite`  in  1  store strobe from the core.
- `Data_add`  in  32  byte address from the core ALU result.
- `write_data`  in  32  store data from the core.
- `sel`  out  1  combinational; 1 when `Data_add[31:3] == BASE_ADDR[31:3]`.
- `rd_data`  out  32  combinational status word; 0 unless `Data_add == BASE_ADDR+4`.
- `tx`  out  1  serial line; idle high.
- `tx_busy`  out  1  1 while the FSM is not IDLE.
- `overflow`  out  1  sticky drop flag.

## Operation
- **TXDATA (BASE+0), store:** push `write_data[7:0]`; bits [31:8] ignored.
  - If the FIFO is full with no pop that cycle, drop the byte and set `overflow`.
- **STATUS (BASE+4):**
  - Load: `rd_data` = {28'b0, overflow, tx_busy, fifo_empty, fifo_full}.
  - Store: if `write_data[3]`=1, clear `overflow`; other bits ignored.
  - A store that sets `overflow` wins over a clear in the same cycle. A single cycle cannot contain both, since there is one address per cycle.
- **Address decode:** any other address, including unaligned addresses in the window, is ignored. Loads have no side effects.
- **FIFO:** circular buffer with read/write pointers and an occupancy count (width clog2(FIFO_DEPTH)+1).
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle while full: push accepted, count unchanged.
  - Push and pop while empty is impossible, because pop requires non-empty.
- **FSM states:** IDLE, START, DATA, STOP. Registers: `shreg[7:0]`, `bitcnt[2:0]`, `baudcnt`.
  - IDLE: `tx`=1. If FIFO non-empty: pop into `shreg`, clear `baudcnt`, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with `bitcnt`=0.
  - DATA: `tx`=`shreg[0]`. Each CLKS_PER_BIT cycles, shift right and increment `bitcnt`. After bit 7, go to STOP. Order is LSB first.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then, if FIFO non-empty, pop and go to START (no idle gap); otherwise go to IDLE.
- `tx` is driven from a register, so it is glitch-free.

## Timing
- **Reset values:** FIFO emptied, FSM=IDLE, `tx`=1, `tx_busy`=0, `overflow`=0, all counters 0.
- **Reset mid-frame:** the frame aborts and `tx`=1 from the cycle after the reset edge. Queued bytes are lost.
- **First-byte latency:**
  - Store accepted at edge E; FIFO non-empty after E.
  - Pop at edge E+1; `tx` falls and `tx_busy` rises after E+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles. Bit k (start=0, data 1–8, stop=9) occupies cycles [k·CPB, (k+1)·CPB) after the pop edge.
- **Back-to-back frames:** the start bit of frame n+1 begins on the cycle right after the last stop-bit cycle of frame n.
- **Status timing:** `fifo_full`/`fifo_empty` reflect registered state, so a load in the cycle of a store sees the pre-store state.
- **Overflow timing:** `overflow` rises the cycle after the dropped store.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, store 32'hABCD_0055 to 0x100.
  - `tx` low for cycles 1–4 after E.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - `tx_busy` high for 40 cycles, then `fifo_empty`=1.
- **Back-to-back:** store 0x01 then 0x80 on consecutive cycles.
  - Two frames with no idle cycle between the stop bit and the next start bit.
  - Decoded bytes are 0x01, 0x80.
- **Overflow:** FIFO_DEPTH=4, six stores issued while the first frame starts.
  - First byte pops, 4 fit, 1 dropped, so `overflow`=1.
  - Load 0x104 returns bit3=1.
  - Store 32'h8 to 0x104 gives `overflow`=0 the next cycle.
- **Push while full at pop edge:** full FIFO, store coincides with the STOP→START pop.
  - Store accepted, `overflow` stays 0, all bytes transmitted in order.
- **Address filter:** stores to 0x0FC, 0x108, 0x101, and a load from 0x100.
  - No FIFO change, `tx` stays 1.
  - `rd_data`=0 except at 0x104; `sel`=1 only for 0x100–0x107.
- **Reset mid-frame:** assert `reset` during data bit 3.
  - `tx`=1, `tx_busy`=0, `fifo_empty`=1 the next cycle.
  - A subsequent store transmits a correct frame.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes core stores to TXDATA/STATUS,
// queues bytes in a small FIFO and serialises them LSB first on a registered tx line.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] Data_add,
    input  logic [31:0] write_data,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        tx_busy,
    output logic        overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_reg, state_next;
    logic [7:0]          shreg_reg, shreg_next;
    logic [2:0]          bitcnt_reg, bitcnt_next;
    logic [BAUD_W-1:0]   baudcnt_reg, baudcnt_next;
    logic                tx_reg, tx_next;

    logic [PTR_W-1:0]    rptr_reg, wptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [7:0]          mem [FIFO_DEPTH];
    logic                overflow_reg;

    logic                hit_txdata, hit_status_wr;
    logic                fifo_empty, fifo_full;
    logic                pop, push_ok, drop;
    logic                baud_done;
    logic [7:0]          head;
    logic                unused_bits;

    assign hit_txdata    = memwrite && (Data_add == BASE_ADDR);
    assign hit_status_wr = memwrite && (Data_add == BASE_ADDR + 32'd4);
    assign fifo_empty    = (count_reg == '0);
    assign fifo_full     = (count_reg == CNT_FULL);
    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    assign push_ok       = hit_txdata && (!fifo_full || pop);
    assign drop          = hit_txdata && fifo_full && !pop;
    assign head          = mem[rptr_reg];
    assign unused_bits   = ^write_data[31:8];

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= write_data[7:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) wptr_reg <= wptr_reg + 1'b1;
            if (pop)     rptr_reg <= rptr_reg + 1'b1;
            if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push_ok && pop) count_reg <= count_reg - 1'b1;
        end
    end

    // Setting takes priority over clearing.
    always_ff @(posedge clk) begin
        if (reset)              overflow_reg <= 1'b0;
        else if (drop)          overflow_reg <= 1'b1;
        else if (hit_status_wr && write_data[3]) overflow_reg <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bitcnt_reg  <= '0;
            baudcnt_reg <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bitcnt_reg  <= bitcnt_next;
            baudcnt_reg <= baudcnt_next;
            tx_reg      <= tx_next;
        end
    end

    assign baud_done = (baudcnt_reg == BAUD_LAST);

    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        bitcnt_next  = bitcnt_reg;
        baudcnt_next = baudcnt_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shreg_next   = head;
                    baudcnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baudcnt_next = '0;
                    bitcnt_next  = '0;
                    state_next   = DATA;
                end else begin
                    baudcnt_next = baudcnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baudcnt_next = '0;
                    shreg_next   = {1'b0, shreg_reg[7:1]};
                    if (bitcnt_reg == 3'd7) state_next = STOP;
                    else                    bitcnt_next = bitcnt_reg + 1'b1;
                end else begin
                    baudcnt_next = baudcnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baudcnt_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shreg_next = head;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baudcnt_next = baudcnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx is registered from the next state so it changes exactly on the bit boundary.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx       = tx_reg;
    assign tx_busy  = (state_reg != IDLE);
    assign overflow = overflow_reg;
    assign sel      = (Data_add[31:3] == BASE_ADDR[31:3]);
    assign rd_data  = (Data_add == BASE_ADDR + 32'd4)
                    ? {28'b0, overflow_reg, tx_busy, fifo_empty, fifo_full}
                    : 32'b0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] Data_add;
    logic [31:0] write_data;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx;
    logic        tx_busy;
    logic        overflow;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4),
        .BASE_ADDR   (32'h0000_0100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .Data_add  (Data_add),
        .write_data(write_data),
        .sel       (sel),
        .rd_data   (rd_data),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        memwrite   = we;
        Data_add   = a;
        write_data = d;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("check %s: got %0h", nm, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Samples tx every cycle of one frame, starting just after the pop edge.
    task automatic chk_frame(input string nm, input logic [7:0] b);
        int errs = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            int   k;
            logic e;
            k = i / CPB;
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            if (tx !== e || tx_busy !== 1'b1) errs++;
            step();
        end
        total++;
        if (errs == 0) begin
            passed++;
            $display("check frame %s byte %02h ok", nm, b);
        end else begin
            $display("FAIL frame %s byte %02h: %0d bad cycles, required 0", nm, b, errs);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,  1'b1, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_00FC, 32'h55, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0108, 32'h55, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0101, 32'h55, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0104, 32'h0,  1'b1, 32'h2};
        vecs[5] = '{1'b0, 32'h0000_0107, 32'h0,  1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_00F8, 32'h0,  1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0104, 32'h0,  1'b1, 32'h2};
        vecs[8] = '{1'b1, 32'h0000_1100, 32'h55, 1'b0, 32'h0};

        reset = 1'b1;
        drive(1'b0, 32'h104, 32'h0);
        step();
        step();
        chk("reset_tx", {31'b0, tx}, 32'h1);
        chk("reset_busy", {31'b0, tx_busy}, 32'h0);
        chk("reset_ovf", {31'b0, overflow}, 32'h0);
        chk("reset_status", rd_data, 32'h2);
        reset = 1'b0;
        step();

        // Address filter
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wd);
            #1;
            chk($sformatf("sel_v%0d", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
            chk($sformatf("rd_v%0d", i), rd_data, vecs[i].exp_rd);
            step();
            chk($sformatf("tx_v%0d", i), {30'b0, tx, tx_busy}, 32'h2);
        end
        drive(1'b0, 32'h104, 32'h0);
        step();
        step();
        chk("filter_status", rd_data, 32'h2);
        chk("filter_tx", {31'b0, tx}, 32'h1);

        // Single byte
        drive(1'b1, 32'h100, 32'hABCD_0055);
        step();
        drive(1'b0, 32'h104, 32'h0);
        #1;
        chk("single_status_after_push", rd_data, 32'h0);
        step();
        chk_frame("single", 8'h55);
        chk("single_idle_busy", {31'b0, tx_busy}, 32'h0);
        chk("single_idle_status", rd_data, 32'h2);

        // Back-to-back
        drive(1'b1, 32'h100, 32'h01);
        step();
        drive(1'b1, 32'h100, 32'h80);
        step();
        drive(1'b0, 32'h104, 32'h0);
        chk_frame("b2b_0", 8'h01);
        chk_frame("b2b_1", 8'h80);
        chk("b2b_idle_status", rd_data, 32'h2);

        // Overflow, then push while full on the STOP->START pop edge
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h100, 32'hA0 + i);
            step();
            if (i == 4) chk("ovf_before_drop", {31'b0, overflow}, 32'h0);
            if (i == 5) chk("ovf_after_drop", {31'b0, overflow}, 32'h1);
        end
        drive(1'b0, 32'h104, 32'h0);
        #1;
        chk("ovf_status", rd_data, 32'hD);
        drive(1'b1, 32'h104, 32'h8);
        step();
        drive(1'b0, 32'h104, 32'h0);
        #1;
        chk("ovf_cleared", {31'b0, overflow}, 32'h0);
        chk("ovf_cleared_status", rd_data, 32'h5);
        repeat (34) step();
        drive(1'b1, 32'h100, 32'h5A);
        step();
        drive(1'b0, 32'h104, 32'h0);
        #1;
        chk("popedge_ovf", {31'b0, overflow}, 32'h0);
        chk("popedge_status", rd_data, 32'h5);
        chk_frame("q1", 8'hA1);
        chk_frame("q2", 8'hA2);
        chk_frame("q3", 8'hA3);
        chk_frame("q4", 8'hA4);
        chk_frame("q5", 8'h5A);
        chk("queue_idle_status", rd_data, 32'h2);

        // Reset mid-frame during data bit 3
        drive(1'b1, 32'h100, 32'h3C);
        step();
        drive(1'b1, 32'h100, 32'h11);
        step();
        drive(1'b1, 32'h100, 32'h22);
        step();
        drive(1'b0, 32'h104, 32'h0);
        repeat (15) step();
        chk("midframe_busy", {31'b0, tx_busy}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_tx", {31'b0, tx}, 32'h1);
        chk("rst_mid_busy", {31'b0, tx_busy}, 32'h0);
        chk("rst_mid_status", rd_data, 32'h2);
        begin
            int errs = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (tx !== 1'b1 || tx_busy !== 1'b0) errs++;
            end
            chk("rst_queue_lost", errs, 0);
        end
        drive(1'b1, 32'h100, 32'hC3);
        step();
        drive(1'b0, 32'h104, 32'h0);
        step();
        chk_frame("after_reset", 8'hC3);
        chk("final_status", rd_data, 32'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
